// File: rtl/apb_gpio_ext.sv
`default_nettype none
// ============================================================================
// Module   : apb_gpio_ext
// Brief    : APB3 GPIO controller with per-pin config, 2-flop input sync,
//            sticky W1C interrupts and atomic OUT_SET/OUT_CLR.
//            Optional input debounce filter: define GPIO_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module apb_gpio_ext #(
  parameter int unsigned       IO_NUM          = 2,
  parameter logic [IO_NUM-1:0] OUT_RESET_VAL   = '0,
  parameter int unsigned       DEBOUNCE_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [IO_NUM-1:0] GPIO_IN,
  output logic [IO_NUM-1:0] GPIO_OUT,
  output logic [IO_NUM-1:0] GPIO_OE,
  output logic [IO_NUM-1:0] INT,
  output logic              INT_OR
);

  localparam logic [5:0] WORD_INTR = 6'h20;
  localparam logic [5:0] WORD_IN   = 6'h24;
  localparam logic [5:0] WORD_OUT  = 6'h28;
  localparam logic [5:0] WORD_SET  = 6'h29;
  localparam logic [5:0] WORD_CLR  = 6'h2A;

  logic [7:0]        cfg [IO_NUM];
  logic [IO_NUM-1:0] out_q, out_next, intr_q, w1c_mask;
  logic [IO_NUM-1:0] sync1, sync2, pin_val, pin_val_d, event_hit;
  logic [IO_NUM-1:0] out_en, in_en, oe, int_en, wdata;

  logic       access, wr, err;
  logic [5:0] word;
  logic [4:0] cfg_idx;
  logic       is_cfg, cfg_ok, is_intr, is_in, is_out, is_set, is_clr, mapped;
  logic [31:0] rdata;

  function automatic logic event_of(input logic [2:0] kind, input logic v, input logic vd);
    case (kind)
      3'd0:    return v;
      3'd1:    return ~v;
      3'd2:    return v & ~vd;
      3'd3:    return ~v & vd;
      3'd4:    return v ^ vd;
      default: return 1'b0;
    endcase
  endfunction

  // Address decode: the low half of the map is the CONFIG_n array.
  assign word    = PADDR[7:2];
  assign cfg_idx = PADDR[6:2];
  assign is_cfg  = ~PADDR[7];
  assign cfg_ok  = is_cfg && (32'(cfg_idx) < IO_NUM);
  assign is_intr = (word == WORD_INTR);
  assign is_in   = (word == WORD_IN);
  assign is_out  = (word == WORD_OUT);
  assign is_set  = (word == WORD_SET);
  assign is_clr  = (word == WORD_CLR);
  assign mapped  = cfg_ok | is_intr | is_in | is_out | is_set | is_clr;

  assign access  = PSEL & PENABLE;
  assign err     = access & (~mapped | (is_in & PWRITE));
  assign wr      = access & PWRITE & ~err;
  assign wdata   = PWDATA[IO_NUM-1:0];
  assign w1c_mask = (wr && is_intr) ? wdata : '0;

  assign PREADY  = 1'b1;
  assign PSLVERR = err & ~PRESET;
  assign PRDATA  = rdata;

  always_comb begin
    rdata = '0;
    if (access && !PWRITE && !PRESET) begin
      if (cfg_ok) begin
        for (int n = 0; n < IO_NUM; n++) begin
          if (cfg_idx == 5'(n)) rdata = {24'd0, cfg[n]};
        end
      end else if (is_intr) begin
        rdata = 32'(intr_q);
      end else if (is_in) begin
        rdata = 32'(pin_val & in_en);
      end else if (is_out) begin
        rdata = 32'(out_q);
      end
    end
  end

  // Bits whose out-reg-en is clear are never touched by OUT/SET/CLR.
  always_comb begin
    out_next = out_q;
    if (wr && is_out)      out_next = (out_q & ~out_en) | (wdata & out_en);
    else if (wr && is_set) out_next = out_q | (wdata & out_en);
    else if (wr && is_clr) out_next = out_q & ~(wdata & out_en);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      out_q     <= OUT_RESET_VAL;
      intr_q    <= '0;
      sync1     <= '0;
      sync2     <= '0;
      pin_val_d <= '0;
      for (int n = 0; n < IO_NUM; n++) cfg[n] <= '0;
    end else begin
      out_q     <= out_next;
      intr_q    <= (intr_q & ~w1c_mask) | event_hit;
      sync1     <= GPIO_IN;
      sync2     <= sync1;
      pin_val_d <= pin_val;
      for (int n = 0; n < IO_NUM; n++) begin
        if (wr && cfg_ok && (cfg_idx == 5'(n))) cfg[n] <= PWDATA[7:0];
      end
    end
  end

  for (genvar n = 0; n < IO_NUM; n++) begin : g_pin
    assign out_en[n] = cfg[n][0];
    assign in_en[n]  = cfg[n][1];
    assign oe[n]     = cfg[n][2];
    assign int_en[n] = cfg[n][3];
`ifdef GPIO_DEBOUNCE_EN
    logic [15:0] cnt;
    logic        filt;
    // Filtered value follows sync only after DEBOUNCE_CYCLES consecutive disagreements.
    always_ff @(posedge PCLK) begin
      if (PRESET) begin
        cnt  <= '0;
        filt <= 1'b0;
      end else if (sync2[n] == filt) begin
        cnt  <= '0;
      end else if (cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
        cnt  <= '0;
        filt <= sync2[n];
      end else begin
        cnt  <= cnt + 16'd1;
      end
    end
    assign pin_val[n] = filt;
`else
    assign pin_val[n] = sync2[n];
`endif
    assign event_hit[n] = event_of(cfg[n][7:5], pin_val[n], pin_val_d[n]);
  end

  assign GPIO_OUT = out_q;
  assign GPIO_OE  = oe;
  assign INT      = intr_q & int_en;
  assign INT_OR   = |INT;

  logic unused_ok;
  assign unused_ok = ^{PADDR[1:0], PWDATA, DEBOUNCE_CYCLES};

endmodule
`default_nettype wire

// File: tb/tb_apb_gpio_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_gpio_ext
// Brief    : Directed self-checking bench for apb_gpio_ext (IO_NUM=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_gpio_ext;

`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 3 + 4;
`else
  localparam int LAT = 3;
`endif

  logic        PCLK, PRESET, PSEL, PENABLE, PWRITE, PREADY, PSLVERR, INT_OR;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic [7:0]  GPIO_IN, GPIO_OUT, GPIO_OE, INT;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rd;
  logic        er;

  apb_gpio_ext #(.IO_NUM(8), .OUT_RESET_VAL(8'hA5), .DEBOUNCE_CYCLES(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .GPIO_IN(GPIO_IN), .GPIO_OUT(GPIO_OUT), .GPIO_OE(GPIO_OE), .INT(INT), .INT_OR(INT_OR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  // Called 1ns after a rising edge; commits on the second following edge.
  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    tick(1);
    PENABLE = 1'b1;
    #1 e = PSLVERR;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    tick(1);
    PENABLE = 1'b1;
    #1;
    d = PRDATA;
    e = PSLVERR;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    // Reset asserted while an illegal read is in its access phase.
    PRESET = 1'b1; PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 8'hFC;
    PWDATA = '0; GPIO_IN = '0;
    tick(3);
    check_eq("rst_prdata", PRDATA, 32'h0);
    check_eq("rst_pslverr", 32'(PSLVERR), 32'h0);
    check_eq("pready", 32'(PREADY), 32'h1);
    PSEL = 1'b0; PENABLE = 1'b0; PRESET = 1'b0;
    tick(1);

    // 1: reset state
    check_eq("rst_gpio_out", 32'(GPIO_OUT), 32'hA5);
    check_eq("rst_gpio_oe", 32'(GPIO_OE), 32'h0);
    check_eq("rst_int_or", 32'(INT_OR), 32'h0);
    apb_read(8'h80, rd, er);
    check_eq("rst_intr", rd, 32'h0);
    apb_read(8'h00, rd, er);
    check_eq("rst_cfg0", rd, 32'h0);
    check_eq("rst_cfg0_err", 32'(er), 32'h0);

    // 2: outputs and atomic set/clear
    for (int i = 0; i < 8; i++) apb_write(8'(4 * i), 32'h05, er);
    apb_write(8'hA0, 32'h3C, er);
    apb_write(8'hA4, 32'h01, er);
    apb_write(8'hA8, 32'h04, er);
    check_eq("out_0x39", 32'(GPIO_OUT), 32'h39);
    check_eq("oe_ff", 32'(GPIO_OE), 32'hFF);
    apb_read(8'hA0, rd, er);
    check_eq("rd_out", rd, 32'h39);
    apb_read(8'h0C, rd, er);
    check_eq("rd_cfg3", rd, 32'h05);
    apb_write(8'h1C, 32'h04, er);           // pin 7: OE only, out-reg disabled
    apb_write(8'hA4, 32'hFF, er);
    check_eq("set_masked", 32'(GPIO_OUT), 32'h7F);
    apb_write(8'hA8, 32'hFF, er);
    check_eq("clr_masked", 32'(GPIO_OUT), 32'h00);
    apb_read(8'hA4, rd, er);
    check_eq("rd_set_wo", rd, 32'h0);
    check_eq("rd_set_err", 32'(er), 32'h0);

    // 3: rising-edge interrupt latency and W1C
    apb_write(8'h08, 32'h4A, er);
    GPIO_IN[2] = 1'b1;
    tick(LAT - 1);
    check_eq("rise_int_early", 32'(INT), 32'h00);
    tick(1);
    check_eq("rise_int", 32'(INT), 32'h04);
    check_eq("rise_int_or", 32'(INT_OR), 32'h1);
    apb_read(8'h90, rd, er);
    check_eq("rd_in", rd, 32'h04);
    apb_write(8'h80, 32'h04, er);
    check_eq("w1c_int", 32'(INT), 32'h00);
    GPIO_IN[2] = 1'b0;
    tick(LAT + 2);
    apb_read(8'h80, rd, er);
    check_eq("fall_no_set", rd, 32'h0);
    check_eq("fall_int_or", 32'(INT_OR), 32'h0);

    // 4: level-low re-set, then W1C colliding with a rise
    apb_write(8'h04, 32'h2A, er);
    tick(2);
    apb_read(8'h80, rd, er);
    check_eq("lvl_lo_set", rd, 32'h02);
    apb_write(8'h80, 32'h02, er);
    tick(1);
    check_eq("lvl_lo_reset", 32'(INT), 32'h02);
    GPIO_IN[1] = 1'b1;
    tick(LAT + 2);
    apb_write(8'h80, 32'h02, er);
    check_eq("lvl_released", 32'(INT), 32'h00);
    GPIO_IN[2] = 1'b1;
    tick(LAT + 2);
    check_eq("rise_again", 32'(INT), 32'h04);
    GPIO_IN[2] = 1'b0;
    tick(LAT + 2);
    GPIO_IN[2] = 1'b1;
    tick(LAT - 2);
    apb_write(8'h80, 32'h04, er);           // commits on the edge the rise lands
    tick(1);
    apb_read(8'h80, rd, er);
    check_eq("set_wins", rd, 32'h04);
    apb_write(8'h80, 32'h04, er);
    check_eq("w1c_quiet", 32'(INT), 32'h00);

    // 5: error responses, no side effects
    apb_read(8'h20, rd, er);
    check_eq("cfg8_err", 32'(er), 32'h1);
    check_eq("cfg8_data", rd, 32'h0);
    apb_write(8'h90, 32'hFF, er);
    check_eq("wr_in_err", 32'(er), 32'h1);
    apb_read(8'hFC, rd, er);
    check_eq("unmapped_err", 32'(er), 32'h1);
    check_eq("unmapped_data", rd, 32'h0);
    apb_write(8'h20, 32'hFF, er);
    apb_write(8'h84, 32'hFF, er);
    check_eq("err_wr_flag", 32'(er), 32'h1);
    check_eq("err_oe_keep", 32'(GPIO_OE), 32'hF9);
    check_eq("err_out_keep", 32'(GPIO_OUT), 32'h00);
    apb_read(8'h80, rd, er);
    check_eq("err_intr_keep", rd, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    // 6: glitch rejection and filtered latency
    apb_write(8'h0C, 32'h4A, er);
    GPIO_IN[3] = 1'b1;
    tick(2);
    GPIO_IN[3] = 1'b0;
    tick(10);
    check_eq("glitch_int", 32'(INT), 32'h00);
    apb_read(8'h90, rd, er);
    check_eq("glitch_in", rd, 32'h06);
    GPIO_IN[3] = 1'b1;
    tick(6);
    check_eq("deb_int_early", 32'(INT), 32'h00);
    tick(1);
    check_eq("deb_int", 32'(INT), 32'h08);
    apb_read(8'h90, rd, er);
    check_eq("deb_in", rd, 32'h0E);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
